servo_pwm_scanner: RTL

SERVO_PWM_SCANNER -- requirements
Module: servo_pwm_scanner

---
 rtl/servo_pwm_scanner.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/servo_pwm_scanner.sv
// servo_pwm_scanner
//   Reads NUM_CH servo pulse widths (in microseconds) from a RAM via its
//   read-only port B and produces one PWM output per channel. A frame is
//   FRAME_TICKS ticks long, and one tick is CLK_DIV clks (1 us).
//
//   Widths are double buffered. A scan fills shadow[], and shadow[] is
//   copied into active[] at the frame wrap. RAM writes made while a frame
//   is running therefore only take effect in the following frame. The
//   rescan starts at the tick that enters the last tick of a frame. It
//   finishes within that tick (3*NUM_CH+2 <= CLK_DIV), so each frame uses
//   the RAM contents sampled just before the frame begins.
//
// Ports
//   clk         : clock; every flop is rising-edge
//   rst_n       : asynchronous active-low reset
//   enable      : run while high; low stops the outputs and returns to IDLE
//   addr_b      : RAM port-B read address (registered)
//   we_b        : RAM port-B write enable (always 0)
//   data_b      : RAM port-B write data (always 0)
//   q_b         : RAM port-B registered read data
//   pwm_out     : servo pulse outputs (registered)
//   frame_start : one-clk pulse when a frame begins
//   load_done   : one-clk pulse when every shadow width has been captured
module servo_pwm_scanner #(
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 16,
  parameter int NUM_CH      = 8,
  parameter int BASE_ADDR   = 0,
  parameter int CLK_DIV     = 50,
  parameter int FRAME_TICKS = 20000,
  parameter int MIN_US      = 500,
  parameter int MAX_US      = 2500
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  output logic [ADDR_WIDTH-1:0] addr_b,
  output logic                  we_b,
  output logic [DATA_WIDTH-1:0] data_b,
  input  logic [DATA_WIDTH-1:0] q_b,
  output logic [NUM_CH-1:0]     pwm_out,
  output logic                  frame_start,
  output logic                  load_done
);

  localparam int FC_W  = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam int PS_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CMP_W = (FC_W > DATA_WIDTH) ? FC_W : DATA_WIDTH;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_ADDR = 3'd1,
    RD_WAIT = 3'd2,
    RD_CAP  = 3'd3,
    RUN     = 3'd4
  } state_e;

  state_e                state_q;
  logic [CH_W-1:0]       ch_q;
  logic [ADDR_WIDTH-1:0] addr_b_q;
  logic                  load_done_q;
  logic [PS_W-1:0]       presc_q, presc_d;
  logic [FC_W-1:0]       frame_cnt_q, frame_cnt_d;
  logic                  running_q, running_d;
  logic                  frame_start_q, frame_start_d;

  logic [DATA_WIDTH-1:0] q_clamped;
  logic                  tick;
  logic                  wrap;
  logic                  reload;
  logic                  last_cap;
  logic                  first_load;
  logic                  copy_en;

  assign we_b        = 1'b0;
  assign data_b      = '0;
  assign addr_b      = addr_b_q;
  assign load_done   = load_done_q;
  assign frame_start = frame_start_q;

  // Zero means "channel off". Any other width is forced into [MIN_US, MAX_US].
  always_comb begin
    q_clamped = q_b;
    if (q_b == '0) begin
      q_clamped = '0;
    end else if (q_b < DATA_WIDTH'(MIN_US)) begin
      q_clamped = DATA_WIDTH'(MIN_US);
    end else if (q_b > DATA_WIDTH'(MAX_US)) begin
      q_clamped = DATA_WIDTH'(MAX_US);
    end
  end

  // The timebase only runs once the first scan after enable has completed.
  assign tick     = running_q && (presc_q == PS_W'(CLK_DIV - 1));
  assign wrap     = tick && (frame_cnt_q == FC_W'(FRAME_TICKS - 1));
  // Start the rescan when the last tick of the frame begins. It finishes
  // before the wrap.
  assign reload   = (state_q == RUN) && tick && (frame_cnt_q == FC_W'(FRAME_TICKS - 2));
  assign last_cap = (state_q == RD_CAP) && (ch_q == CH_W'(NUM_CH - 1));
  // The first scan after enable starts frame 0 right away. It does not
  // wait for a wrap.
  assign first_load = enable && last_cap && !running_q;
  assign copy_en    = first_load || (enable && wrap);

  always_comb begin
    presc_d       = presc_q;
    frame_cnt_d   = frame_cnt_q;
    running_d     = running_q;
    frame_start_d = 1'b0;
    if (!enable) begin
      presc_d     = '0;
      frame_cnt_d = '0;
      running_d   = 1'b0;
    end else if (first_load) begin
      running_d     = 1'b1;
      presc_d       = '0;
      frame_cnt_d   = '0;
      frame_start_d = 1'b1;
    end else if (running_q) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
      if (wrap) begin
        frame_cnt_d   = '0;
        frame_start_d = 1'b1;
      end else if (tick) begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
  end

  // Scan FSM plus the frame timebase registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      ch_q          <= '0;
      addr_b_q      <= '0;
      load_done_q   <= 1'b0;
      presc_q       <= '0;
      frame_cnt_q   <= '0;
      running_q     <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      presc_q       <= presc_d;
      frame_cnt_q   <= frame_cnt_d;
      running_q     <= running_d;
      frame_start_q <= frame_start_d;
      load_done_q   <= 1'b0;
      if (!enable) begin
        state_q <= IDLE;
        ch_q    <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            ch_q    <= '0;
            state_q <= RD_ADDR;
          end
          RD_ADDR: begin
            addr_b_q <= ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(ch_q);
            state_q  <= RD_WAIT;
          end
          // The RAM registers addr_b on this edge. q_b holds the word
          // during RD_CAP.
          RD_WAIT: state_q <= RD_CAP;
          RD_CAP: begin
            if (last_cap) begin
              load_done_q <= 1'b1;
              state_q     <= RUN;
            end else begin
              ch_q    <= ch_q + 1'b1;
              state_q <= RD_ADDR;
            end
          end
          RUN: begin
            if (reload) begin
              ch_q    <= '0;
              state_q <= RD_ADDR;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // Per-channel shadow/active width registers and pulse comparator.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    localparam bit IS_LAST = (gi == NUM_CH - 1);
    logic [DATA_WIDTH-1:0] shadow_q;
    logic [DATA_WIDTH-1:0] active_q, active_d;
    logic                  pwm_q, pwm_d;

    // On the first load, the last channel is captured on the same edge as
    // the copy. Its value is therefore taken directly from the clamp.
    always_comb begin
      active_d = active_q;
      if (copy_en) begin
        active_d = (first_load && IS_LAST) ? q_clamped : shadow_q;
      end
    end

    // The comparison uses next-state values. pwm_out is then aligned with
    // frame_cnt, and the pulse lasts exactly active*CLK_DIV clks.
    assign pwm_d = running_d && (CMP_W'(frame_cnt_d) < CMP_W'(active_d));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        shadow_q <= '0;
        active_q <= '0;
        pwm_q    <= 1'b0;
      end else begin
        if (enable && (state_q == RD_CAP) && (ch_q == CH_W'(gi))) begin
          shadow_q <= q_clamped;
        end
        active_q <= active_d;
        pwm_q    <= pwm_d;
      end
    end

    assign pwm_out[gi] = pwm_q;
  end

endmodule
